// File: rtl/mem_xfer_pkg.sv
// Shared constants and FSM state encoding for the memory-transfer controller.
package mem_xfer_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_NUM_PAIRS = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_B = 3'd2,
    S_LATCH_B = 3'd3,
    S_CMP     = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6
  } xfer_state_e;

endpackage

// File: rtl/mem_xfer_ctrl.sv
// Streams operand pairs from a synchronous source RAM to an external comparator and
// writes the signed maximum of each pair. Optional statistics: MEM_XFER_STATS_EN.
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_PAIRS = DEF_NUM_PAIRS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] DOut1,
  output logic [DATA_W-1:0] DOut2,
  input  logic              Sign,
  output logic              wr_en,
  output logic [ADDR_W-2:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
`ifdef MEM_XFER_STATS_EN
  output logic [ADDR_W-1:0] gt_cnt,
`endif
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-2:0] LAST_IDX = (ADDR_W-1)'(NUM_PAIRS - 1);

  xfer_state_e       state_q, state_d;
  logic [ADDR_W-2:0] i_q, i_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] dout1_q, dout1_d;
  logic [DATA_W-1:0] dout2_q, dout2_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-2:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State and datapath registers; reset forces IDLE with all outputs cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      sign_q    <= 1'b0;
      dout1_q   <= '0;
      dout2_q   <= '0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      sign_q    <= sign_d;
      dout1_q   <= dout1_d;
      dout2_q   <= dout2_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state sequencing: five states per pair, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH_A;
        else       state_d = S_IDLE;
      end
      S_FETCH_A: state_d = S_FETCH_B;
      S_FETCH_B: state_d = S_LATCH_B;
      S_LATCH_B: state_d = S_CMP;
      S_CMP:     state_d = S_WRITE;
      S_WRITE: begin
        if (i_q == LAST_IDX) state_d = S_DONE;
        else                 state_d = S_FETCH_A;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; outputs are derived from state_d so they
  // line up with the state they belong to while still coming straight from flops.
  always_comb begin
    i_d     = i_q;
    sign_d  = sign_q;
    dout1_d = dout1_q;
    dout2_d = dout2_q;
    case (state_q)
      S_IDLE: begin
        if (start) i_d = '0;
        else       i_d = i_q;
      end
      S_FETCH_B: dout1_d = rd_data;
      S_LATCH_B: dout2_d = rd_data;
      S_CMP:     sign_d  = Sign;
      S_WRITE: begin
        if (i_q != LAST_IDX) i_d = i_q + (ADDR_W-1)'(1);
        else                 i_d = i_q;
      end
      default: i_d = i_q;
    endcase

    // The RAM has one cycle of latency, so the address leads the capture state.
    case (state_d)
      S_FETCH_A: rd_addr_d = {i_d, 1'b0};
      S_FETCH_B: rd_addr_d = {i_q, 1'b1};
      default:   rd_addr_d = '0;
    endcase

    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_d == S_WRITE) begin
      wr_en_d   = 1'b1;
      wr_addr_d = i_q;
      wr_data_d = sign_d ? dout1_q : dout2_q;
    end else begin
      wr_en_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

`ifdef MEM_XFER_STATS_EN
  logic [ADDR_W-1:0] gt_cnt_q, gt_cnt_d;

  // Count pairs whose first operand won; cleared when a transfer is accepted.
  always_comb begin
    gt_cnt_d = gt_cnt_q;
    if (state_q == S_IDLE && start) begin
      gt_cnt_d = '0;
    end else if (state_q == S_WRITE && sign_q) begin
      gt_cnt_d = gt_cnt_q + ADDR_W'(1);
    end else begin
      gt_cnt_d = gt_cnt_q;
    end
  end

  // Statistics register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gt_cnt_q <= '0;
    else     gt_cnt_q <= gt_cnt_d;
  end

  assign gt_cnt = gt_cnt_q;
`endif

  assign rd_addr = rd_addr_q;
  assign DOut1   = dout1_q;
  assign DOut2   = dout2_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed bench for mem_xfer_ctrl with a behavioural source RAM and signed comparator.
module tb_mem_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] DOut1, DOut2;
  logic       Sign;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, done;
`ifdef MEM_XFER_STATS_EN
  logic [3:0] gt_cnt;
`endif

  logic [7:0] src     [16];
  logic [7:0] exp_max [8];
  logic [7:0] dst     [8];
  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt;

  mem_xfer_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .DOut1   (DOut1),
    .DOut2   (DOut2),
    .Sign    (Sign),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`ifdef MEM_XFER_STATS_EN
    .gt_cnt  (gt_cnt),
`endif
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Synchronous source RAM with one cycle of read latency.
  always @(posedge clk) rd_data <= src[rd_addr];

  assign Sign = ($signed(DOut1) > $signed(DOut2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  // One full transfer; poke>0 pulses start while busy, hold keeps start high throughout.
  task automatic run_xfer(input int poke, input bit hold);
    int cyc;
    bit seen;
    logic [3:0] a;
    wr_cnt = 0;
    for (int p = 0; p < 8; p++) dst[p] = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    if (!hold) start = 1'b0;
    chk("first_rd_addr", rd_addr, 0);
    chk("busy_on", busy, 1);
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke == cyc) start = 1'b1;
      else if (!hold) start = 1'b0;
      if (wr_en) begin
        dst[wr_addr] = wr_data;
        wr_cnt++;
        a = {wr_addr, 1'b0};
        chk($sformatf("dout1_p%0d", wr_addr), DOut1, src[a]);
        a = {wr_addr, 1'b1};
        chk($sformatf("dout2_p%0d", wr_addr), DOut2, src[a]);
      end
      if (done) seen = 1'b1;
    end
    // Inclusive count: the start-sampling edge through the edge that raises done.
    chk("latency", cyc, 41);
    chk("wr_cnt", wr_cnt, 8);
    for (int p = 0; p < 8; p++) chk($sformatf("max_p%0d", p), dst[p], exp_max[p]);
`ifdef MEM_XFER_STATS_EN
    chk("gt_cnt", gt_cnt, 5);
`endif
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rd_addr", rd_addr, 0);
    chk("idle_wr_en", wr_en, 0);
  endtask

  initial begin
    int cyc;
    bit found;
    // {A,B} pairs: gt, lt, gt, eq, gt, lt, gt, gt -> five pairs with A > B
    src[0]  = 8'h03; src[1]  = 8'h01;
    src[2]  = 8'h80; src[3]  = 8'h83;
    src[4]  = 8'h9F; src[5]  = 8'h8F;
    src[6]  = 8'h07; src[7]  = 8'h07;
    src[8]  = 8'h7F; src[9]  = 8'h80;
    src[10] = 8'hFF; src[11] = 8'h01;
    src[12] = 8'h10; src[13] = 8'hF0;
    src[14] = 8'h22; src[15] = 8'h21;
    exp_max[0] = 8'h03; exp_max[1] = 8'h83; exp_max[2] = 8'h9F; exp_max[3] = 8'h07;
    exp_max[4] = 8'h7F; exp_max[5] = 8'h01; exp_max[6] = 8'h10; exp_max[7] = 8'h22;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_dout1", DOut1, 0);
    chk("rst_dout2", DOut2, 0);
    chk("rst_wr_data", wr_data, 0);
    @(negedge clk);
    rst = 1'b0;

    run_xfer(0, 1'b0);
    chk("dout1_hold", DOut1, 8'h22);
    chk("dout2_hold", DOut2, 8'h21);
    run_xfer(7, 1'b0);
    run_xfer(0, 1'b1);
    run_xfer(0, 1'b0);

    // Abort in the WRITE cycle of pair 3.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wr_en && wr_addr == 3'd3) found = 1'b1;
    end
    chk("reach_pair3", found, 1);
    rst = 1'b1;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_addr", rd_addr, 0);
    chk("abort_wr_addr", wr_addr, 0);
    chk("abort_wr_data", wr_data, 0);
    chk("abort_dout1", DOut1, 0);
    chk("abort_dout2", DOut2, 0);
    @(negedge clk);
    rst = 1'b0;
    wr_cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (wr_en || busy) wr_cnt++;
    end
    chk("abort_quiet", wr_cnt, 0);
    run_xfer(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_xfer_ctrl.md
MEM_XFER_CTRL -- requirements
Module: mem_xfer_ctrl

Interface
- REQ-001: One clock; reset is asynchronous and active-high; ports clk and rst.
- REQ-002: Parameter DATA_W, default 8, word width.
- REQ-003: Parameter ADDR_W, default 4, source-memory address width.
- REQ-004: Parameter NUM_PAIRS, default 8, operand pairs per transfer (2*NUM_PAIRS <= 2**ADDR_W).
- REQ-005: clk  input  1  rising-edge clock.
- REQ-006: rst  input  1  async active-high reset.
- REQ-007: start  input  1  begin transfer; sampled only in IDLE.
- REQ-008: rd_addr  output  ADDR_W  source-memory read address (synchronous RAM, 1-cycle read latency).
- REQ-009: rd_data  input  DATA_W  source-memory read data.
- REQ-010: DOut1  output  DATA_W  first comparator operand (registered).
- REQ-011: DOut2  output  DATA_W  second comparator operand (registered).
- REQ-012: Sign  input  1  comparator result; 1 iff DOut1 > DOut2 as two's complement, else 0.
- REQ-013: wr_en  output  1  destination-memory write strobe.
- REQ-014: wr_addr  output  ADDR_W-1  destination address (pair index).
- REQ-015: wr_data  output  DATA_W  destination write data.
- REQ-016: busy  output  1  high in every state except IDLE.
- REQ-017: done  output  1  one-cycle pulse when the transfer completes.

Function
- REQ-018: FSM states IDLE, FETCH_A, FETCH_B, LATCH_B, CMP, WRITE, DONE.
- REQ-019: IDLE -> FETCH_A when start=1; pair index i cleared to 0.
- REQ-020: FETCH_A: rd_addr=2i; -> FETCH_B.
- REQ-021: FETCH_B: rd_addr=2i+1; DOut1 <= rd_data; -> LATCH_B.
- REQ-022: LATCH_B: DOut2 <= rd_data; -> CMP.
- REQ-023: CMP: Sign registered into sign_q; -> WRITE.
- REQ-024: WRITE: wr_en=1, wr_addr=i, wr_data = sign_q ? DOut1 : DOut2 (signed maximum); equal operands write DOut2.
- REQ-025: WRITE -> DONE if i==NUM_PAIRS-1, else i <= i+1 and -> FETCH_A.
- REQ-026: DONE: done=1 for exactly one cycle; -> IDLE.
- REQ-027: Latency 5 cycles per pair; total transfer 5*NUM_PAIRS+1 cycles from the first FETCH_A to done.
- REQ-028: start while busy is ignored; start held high in IDLE after DONE begins a new transfer.
- REQ-029: wr_en is high only in WRITE; rd_addr holds 0 in IDLE.
- REQ-030: DOut1/DOut2 hold their last values between transfers.

Reset
- REQ-031: rst asserted at any time forces IDLE immediately; i, sign_q, DOut1, DOut2, rd_addr, wr_addr, wr_data = 0; wr_en, busy, done = 0.
- REQ-032: Reset mid-transfer aborts with no further writes; the next start restarts at pair 0.

Configuration
- REQ-033: Macro MEM_XFER_STATS_EN defined: adds output gt_cnt [ADDR_W-1:0], cleared on start, incremented in WRITE when sign_q=1, held after DONE.
- REQ-034: Macro MEM_XFER_STATS_EN undefined: gt_cnt port and its logic are absent; all other behaviour identical.

Structure
- REQ-035: Shared package mem_xfer_pkg holds the FSM state enumeration and the default DATA_W/ADDR_W/NUM_PAIRS constants.
- REQ-036: Single module; no sub-module. The comparator is instantiated externally alongside this block.

Verification
- REQ-037: Reset mid-WRITE (rst pulse during pair 3) -> wr_en=0 on the same cycle, state IDLE, busy=0, outputs 0.
- REQ-038: Source {3,1} at addr 0/1, start -> DOut1=8'h03, DOut2=8'h01, Sign=1, write addr 0 = 8'h03.
- REQ-039: Source {8'h80, 8'h83} -> Sign=0, writes 8'h83; source {8'h9F, 8'h8F} -> Sign=1, writes 8'h9F.
- REQ-040: Equal pair {8'h07, 8'h07} -> Sign=0, writes 8'h07; full 8-pair run -> done pulses once, 41 cycles after start is sampled.
- REQ-041: start pulsed while busy -> no restart; i and writes unaffected; back-to-back start after done -> second run begins at addr 0.
- REQ-042: With MEM_XFER_STATS_EN defined, 8 pairs with 5 having DOut1 > DOut2 -> gt_cnt=5 at done.
